aes_sub_shift_rows: RTL and testbench



---
 rtl/aes_pkg.sv | 25 ++
 rtl/aes_sbox.sv | 30 +++
 rtl/aes_sub_shift_rows.sv | 90 +++++++++
 tb/tb_aes_sub_shift_rows.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// Shared AES-128 datapath definitions used by the round stages
// (SubBytes/ShiftRows, MixColumns, AddRoundKey).
package aes_pkg;

    localparam int AES_STATE_W = 32'd128;
    localparam int AES_WORD_W  = 32'd32;
    localparam int AES_BYTE_W  = 32'd8;
    localparam int AES_NCOLS   = 32'd4;

    // Sequencer states of the iterative SubBytes+ShiftRows stage
    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_PROC = 1'b1
    } ssr_state_e;

    // Byte (row, col) of a state vector; byte k = 4*col + row sits at [8k +: 8]
    function automatic logic [AES_BYTE_W-1:0] get_state_byte(
        input logic [AES_STATE_W-1:0] s,
        input logic [1:0]             row,
        input logic [1:0]             col
    );
        return s[{col, row, 3'b000} +: AES_BYTE_W];
    endfunction

endpackage

// File: rtl/aes_sbox.sv
// Combinational AES forward S-box (FIPS-197 table lookup).
module aes_sbox
    import aes_pkg::*;
(
    input  logic [AES_BYTE_W-1:0] i_byte,
    output logic [AES_BYTE_W-1:0] o_byte
);

    localparam logic [7:0] SBOX_ROM [0:255] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    assign o_byte = SBOX_ROM[i_byte];

endmodule

// File: rtl/aes_sub_shift_rows.sv
// Iterative SubBytes+ShiftRows: one output column per clock through four
// S-boxes, result presented in the MixColumns byte layout with a done pulse.
module aes_sub_shift_rows
    import aes_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   enable,
    input  logic [AES_STATE_W-1:0] state,
    output logic [AES_STATE_W-1:0] state_out,
    output logic                   done,
    output logic                   busy
);

    ssr_state_e             r_fsm;
    logic [1:0]             r_col;
    logic [AES_STATE_W-1:0] r_state_q;
    logic [AES_STATE_W-1:0] r_state_out;
    logic                   r_done;
    logic                   r_busy;

    logic [AES_BYTE_W-1:0]  w_sbox_in  [AES_NCOLS];
    logic [AES_BYTE_W-1:0]  w_sbox_out [AES_NCOLS];
    logic [AES_WORD_W-1:0]  w_col_word;

    // Row r of the current output column reads source column (col + r) mod 4;
    // the 2-bit add wraps naturally, which is exactly the ShiftRows rotation.
    for (genvar g = 0; g < AES_NCOLS; g++) begin : g_row
        logic [1:0] w_src_col;
        assign w_src_col    = r_col + 2'(g);
        assign w_sbox_in[g] = get_state_byte(r_state_q, 2'(g), w_src_col);

        aes_sbox u_sbox (
            .i_byte (w_sbox_in[g]),
            .o_byte (w_sbox_out[g])
        );
    end

    // Row 0 lands in the least significant byte of the column word
    assign w_col_word = {w_sbox_out[3], w_sbox_out[2], w_sbox_out[1], w_sbox_out[0]};

    // Sequencer: capture in IDLE, write one column per cycle in PROC, pulse done on the last
    always_ff @(posedge clk) begin
        if (rst) begin
            r_fsm       <= ST_IDLE;
            r_col       <= 2'd0;
            r_state_q   <= '0;
            r_state_out <= '0;
            r_done      <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            case (r_fsm)
                ST_IDLE: begin
                    r_done <= 1'b0;
                    if (enable) begin
                        r_state_q <= state;
                        r_col     <= 2'd0;
                        r_busy    <= 1'b1;
                        r_fsm     <= ST_PROC;
                    end else begin
                        r_busy <= 1'b0;
                    end
                end
                ST_PROC: begin
                    r_state_out[{r_col, 5'b00000} +: AES_WORD_W] <= w_col_word;
                    r_col <= r_col + 2'd1;
                    if (r_col == 2'd3) begin
                        r_done <= 1'b1;
                        r_busy <= 1'b0;
                        r_fsm  <= ST_IDLE;
                    end else begin
                        r_done <= 1'b0;
                        r_busy <= 1'b1;
                    end
                end
                default: begin
                    r_fsm  <= ST_IDLE;
                    r_col  <= 2'd0;
                    r_done <= 1'b0;
                    r_busy <= 1'b0;
                end
            endcase
        end
    end

    assign state_out = r_state_out;
    assign done      = r_done;
    assign busy      = r_busy;

endmodule

// File: tb/tb_aes_sub_shift_rows.sv
// Self-checking bench for aes_sub_shift_rows. The reference S-box is derived
// from GF(2^8) inversion plus the affine map, not from a lookup table.
module tb_aes_sub_shift_rows;

    logic         clk;
    logic         rst;
    logic         enable;
    logic [127:0] state;
    logic [127:0] state_out;
    logic         done;
    logic         busy;

    int n_tests;
    int n_fail;
    int n_overlap;

    logic [7:0] sbox_ref [256];

    aes_sub_shift_rows dut (
        .clk       (clk),
        .rst       (rst),
        .enable    (enable),
        .state     (state),
        .state_out (state_out),
        .done      (done),
        .busy      (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // done and busy must never be high together
    always @(negedge clk) begin
        if (done === 1'b1 && busy === 1'b1) n_overlap++;
    end

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        logic [7:0] y;
        p = 8'h00; x = a; y = b;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) p = p ^ x;
            x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
            y = y >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
        return (v << n) | (v >> (8 - n));
    endfunction

    task automatic build_sbox();
        logic [7:0] inv;
        for (int b = 0; b < 256; b++) begin
            inv = 8'h00;
            for (int x = 1; x < 256; x++) begin
                if (gmul(8'(b), 8'(x)) == 8'h01) inv = 8'(x);
            end
            sbox_ref[b] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
        end
    endtask

    // out(r,c) = SBOX(in(r, (c+r) mod 4))
    function automatic logic [127:0] model(input logic [127:0] s);
        logic [127:0] o;
        int src;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                src = 4 * ((c + r) % 4) + r;
                o[8 * (4 * c + r) +: 8] = sbox_ref[s[8 * src +: 8]];
            end
        end
        return o;
    endfunction

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Capture v, then wait (bounded) for done; lat = cycles after capture edge
    task automatic run_block(input logic [127:0] v, output int lat);
        enable = 1'b1;
        state  = v;
        tick();
        enable = 1'b0;
        lat = 0;
        while (done !== 1'b1 && lat < 10) begin
            tick();
            lat++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; enable = 1'b0; state = '0;
        tick(); tick();
        rst = 1'b0;
        n_tests++; if (state_out !== 128'h0) begin n_fail++; $display("FAIL reset_state_out: got %h want 0", state_out); end
        n_tests++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", done); end
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
        // reset and enable together: reset wins, nothing captured
        rst = 1'b1; enable = 1'b1; state = rand128();
        tick();
        rst = 1'b0; enable = 1'b0;
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_vs_enable_busy: got %b want 0", busy); end
        tick();
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_vs_enable_idle: got %b want 0", busy); end
    endtask

    task automatic test_zero();
        int lat;
        enable = 1'b1; state = '0;
        tick();
        enable = 1'b0;
        n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL zero_busy_at_capture: got %b want 1", busy); end
        lat = 0;
        while (done !== 1'b1 && lat < 10) begin tick(); lat++; end
        n_tests++; if (lat !== 4) begin n_fail++; $display("FAIL zero_latency: got %0d want 4", lat); end
        n_tests++; if (state_out !== {16{8'h63}}) begin n_fail++; $display("FAIL zero_result: got %h want %h", state_out, {16{8'h63}}); end
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL zero_busy_at_done: got %b want 0", busy); end
        tick();
        n_tests++; if (done !== 1'b0) begin n_fail++; $display("FAIL zero_done_pulse: got %b want 0", done); end
    endtask

    task automatic test_fips();
        logic [7:0] fin  [16] = '{8'h19, 8'h3d, 8'he3, 8'hbe, 8'ha0, 8'hf4, 8'he2, 8'h2b,
                                  8'h9a, 8'hc6, 8'h8d, 8'h2a, 8'he9, 8'hf8, 8'h48, 8'h08};
        logic [7:0] fout [16] = '{8'hd4, 8'hbf, 8'h5d, 8'h30, 8'he0, 8'hb4, 8'h52, 8'hae,
                                  8'hb8, 8'h41, 8'h11, 8'hf1, 8'h1e, 8'h27, 8'h98, 8'he5};
        logic [127:0] vin;
        logic [127:0] vexp;
        int lat;
        for (int k = 0; k < 16; k++) begin
            vin[8 * k +: 8]  = fin[k];
            vexp[8 * k +: 8] = fout[k];
        end
        run_block(vin, lat);
        n_tests++; if (lat !== 4) begin n_fail++; $display("FAIL fips_latency: got %0d want 4", lat); end
        n_tests++; if (state_out !== vexp) begin n_fail++; $display("FAIL fips_result: got %h want %h", state_out, vexp); end
        n_tests++; if (model(vin) !== vexp) begin n_fail++; $display("FAIL fips_ref_model: got %h want %h", model(vin), vexp); end
        tick();
    endtask

    task automatic test_midblock_ignore();
        logic [127:0] v;
        logic [127:0] cap;
        int n_done;
        v = rand128(); cap = '0; n_done = 0;
        enable = 1'b1; state = v;
        tick();
        for (int i = 1; i <= 8; i++) begin
            enable = (i <= 4) ? 1'b1 : 1'b0;
            state  = rand128();
            tick();
            if (done === 1'b1) begin n_done++; cap = state_out; end
        end
        n_tests++; if (n_done !== 1) begin n_fail++; $display("FAIL midblock_done_count: got %0d want 1", n_done); end
        n_tests++; if (cap !== model(v)) begin n_fail++; $display("FAIL midblock_result: got %h want %h", cap, model(v)); end
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL midblock_no_restart: got %b want 0", busy); end
    endtask

    task automatic test_back_to_back();
        logic [127:0] va;
        logic [127:0] vb;
        logic [127:0] vec [6];
        logic [127:0] snap;
        int blk;
        int last_done;
        va = rand128(); vb = rand128();
        for (int i = 0; i < 6; i++) vec[i] = (i % 2 == 0) ? va : vb;
        blk = 0; last_done = -1; snap = '0;
        enable = 1'b1; state = vec[0];
        tick();
        state = vec[1];
        for (int t = 1; t <= 26 && blk < 5; t++) begin
            tick();
            if (t % 5 == 0) state = vec[t / 5 + 1];
            if (last_done >= 0 && t == last_done + 1) begin
                n_tests++; if (state_out !== snap) begin n_fail++; $display("FAIL b2b_stable_blk%0d: got %h want %h", blk, state_out, snap); end
            end
            if (done === 1'b1) begin
                n_tests++; if (t !== 5 * blk + 4) begin n_fail++; $display("FAIL b2b_done_time_blk%0d: got %0d want %0d", blk, t, 5 * blk + 4); end
                n_tests++; if (state_out !== model(vec[blk])) begin n_fail++; $display("FAIL b2b_result_blk%0d: got %h want %h", blk, state_out, model(vec[blk])); end
                snap = state_out;
                last_done = t;
                blk++;
                if (blk == 5) enable = 1'b0;
            end
        end
        n_tests++; if (blk !== 5) begin n_fail++; $display("FAIL b2b_block_count: got %0d want 5", blk); end
        enable = 1'b0;
        tick(); tick(); tick(); tick(); tick(); tick();
    endtask

    task automatic test_reset_midblock();
        logic [127:0] v;
        int n_done;
        int lat;
        v = rand128(); n_done = 0;
        enable = 1'b1; state = v;
        tick();
        enable = 1'b0;
        tick(); tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL midrst_busy: got %b want 0", busy); end
        n_tests++; if (done !== 1'b0) begin n_fail++; $display("FAIL midrst_done: got %b want 0", done); end
        n_tests++; if (state_out !== 128'h0) begin n_fail++; $display("FAIL midrst_state_out: got %h want 0", state_out); end
        for (int i = 0; i < 5; i++) begin
            tick();
            if (done === 1'b1) n_done++;
        end
        n_tests++; if (n_done !== 0) begin n_fail++; $display("FAIL midrst_stray_done: got %0d want 0", n_done); end
        v = rand128();
        run_block(v, lat);
        n_tests++; if (lat !== 4) begin n_fail++; $display("FAIL midrst_fresh_latency: got %0d want 4", lat); end
        n_tests++; if (state_out !== model(v)) begin n_fail++; $display("FAIL midrst_fresh_result: got %h want %h", state_out, model(v)); end
        tick();
    endtask

    task automatic test_random();
        logic [127:0] v;
        int lat;
        for (int n = 0; n < 10; n++) begin
            v = rand128();
            run_block(v, lat);
            n_tests++; if (lat !== 4) begin n_fail++; $display("FAIL rand_latency_%0d: got %0d want 4", n, lat); end
            n_tests++; if (state_out !== model(v)) begin n_fail++; $display("FAIL rand_result_%0d: got %h want %h", n, state_out, model(v)); end
            tick();
        end
    endtask

    task automatic test_done_busy_exclusive();
        n_tests++; if (n_overlap !== 0) begin n_fail++; $display("FAIL done_busy_overlap: got %0d cycles want 0", n_overlap); end
    endtask

    initial begin
        n_tests = 0; n_fail = 0; n_overlap = 0;
        rst = 1'b1; enable = 1'b0; state = '0;
        build_sbox();
        test_reset();
        test_zero();
        test_fips();
        test_midblock_ignore();
        test_back_to_back();
        test_reset_midblock();
        test_random();
        test_done_busy_exclusive();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
